// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per PC, a one-entry output buffer towards the IDU,
// and a pc_adv pulse back to the PC stage whenever the buffered instruction is consumed.
module ysyx_23060203_ifu #(
    parameter int          ADDR_W  = 32,
    parameter int          INST_W  = 32,
    parameter logic [1:0]  RESP_OK = 2'b00
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_adv,
    input  logic              flush,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [INST_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_fault,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t state;
    logic   drop;
    logic   addr_ok;

    // Handshakes: a transfer happens on a rising edge where valid && ready; a raised valid and its
    // payload are held unchanged until that edge, and ready never depends on the other side's valid.
    assign pc_adv    = (state == S_OUT) && out_ready && !flush;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            drop      <= 1'b0;
            addr_ok   <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            out_valid <= 1'b0;
            araddr    <= '0;
            out_inst  <= '0;
            out_pc    <= '0;
            out_fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    araddr  <= pc_in;
                    out_pc  <= pc_in;
                    addr_ok <= 1'b1;
                    arvalid <= 1'b1;
                    state   <= S_REQ;
                end
                S_REQ: begin
                    if (!addr_ok) begin
                        // Setup cycle: pc_in now shows the PC stage's updated value. A redirect
                        // arriving here is simply picked up one cycle later.
                        if (!flush) begin
                            araddr  <= pc_in;
                            out_pc  <= pc_in;
                            addr_ok <= 1'b1;
                            arvalid <= 1'b1;
                        end
                    end else begin
                        if (flush) begin
                            drop <= 1'b1;
                        end
                        if (arready) begin
                            arvalid <= 1'b0;
                            addr_ok <= 1'b0;
                            rready  <= 1'b1;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (drop || flush) begin
                            drop    <= 1'b0;
                            araddr  <= pc_in;
                            out_pc  <= pc_in;
                            addr_ok <= 1'b1;
                            arvalid <= 1'b1;
                            state   <= S_REQ;
                        end else begin
                            out_inst  <= rdata;
                            out_fault <= (rresp != RESP_OK);
                            out_valid <= 1'b1;
                            state     <= S_OUT;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    // Flush wins over out_ready; either way the next address is sampled one cycle
                    // later, after the PC stage has updated.
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        addr_ok   <= 1'b0;
                        state     <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Randomized bench for the IFU: a behavioural PC stage, an AXI4-Lite memory with random stalls,
// and a scoreboard that expects each consumed instruction to be the memory word at the PC stage's PC.
module tb_ysyx_23060203_ifu;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_adv;
    logic              flush;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [INST_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_fault;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    ysyx_23060203_ifu #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESP_OK(2'b00)) dut (
        .clk(clk), .rstn(rstn), .pc_in(pc_in), .pc_adv(pc_adv), .flush(flush),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_fault(out_fault), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    logic [INST_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    int                rd_cnt;
    logic [ADDR_W-1:0] pc;

    int p_arready, min_rdelay, max_rdelay, p_ready, p_flush;
    int cycle = 0;
    int last_acc = -1;
    int accepts = 0;
    bit chk_gap = 0;
    bit flushed = 0;
    bit force_flush = 0;
    logic [ADDR_W-1:0] force_pc;
    bit hold_ar = 0;
    bit hold_out = 0;
    logic [ADDR_W-1:0] held_araddr;
    logic [64:0] held_out;
    bit seen;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic bit is_fault(input logic [ADDR_W-1:0] a);
        return (a == 32'h0) || (a[6:2] == 5'd9);
    endfunction

    // The PC stage's PC determines the one instruction the IDU may receive next.
    task automatic set_pc();
        exp_q.delete();
        exp_q.push_back(mem_word(pc));
    endtask

    task automatic step();
        bit ar_hs, r_hs, acc;
        @(negedge clk);
        cycle++;
        if (hold_ar) check("ar_stable", {arvalid, araddr}, {1'b1, held_araddr});
        if (hold_out) check("out_stable", {out_valid, out_fault, out_pc, out_inst}, {1'b1, held_out});

        flush = 1'b0;
        if (force_flush || $urandom_range(99) < p_flush) begin
            flush   = 1'b1;
            flushed = 1'b1;
            pc      = force_flush ? force_pc : ($urandom & 32'hFFFF_FFFC);
            force_flush = 0;
            set_pc();
        end
        pc_in     = pc;
        arready   = ($urandom_range(99) < p_arready);
        out_ready = ($urandom_range(99) < p_ready);
        rvalid    = 1'b0;
        rdata     = $urandom;
        rresp     = 2'(($urandom_range(3)));
        if (rd_q.size() > 0) begin
            if (rd_cnt == 0) begin
                rvalid = 1'b1;
                rdata  = mem_word(rd_q[0]);
                rresp  = is_fault(rd_q[0]) ? 2'b10 : 2'b00;
            end else begin
                rd_cnt--;
            end
        end
        #1;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        acc   = out_valid && out_ready && !flush;
        check("pc_adv", pc_adv, acc);
        if (ar_hs) begin
            check("one_outstanding", rd_q.size(), 0);
            if (!flushed) check("araddr", araddr, pc);
            rd_q.push_back(araddr);
            rd_cnt = $urandom_range(max_rdelay, min_rdelay);
        end
        if (r_hs && rd_q.size() > 0) void'(rd_q.pop_front());
        hold_ar     = arvalid && !arready;
        held_araddr = araddr;
        hold_out    = out_valid && !out_ready && !flush;
        held_out    = {out_fault, out_pc, out_inst};
        if (acc) begin
            accepts++;
            check("out_pc", out_pc, pc);
            check("out_fault", out_fault, is_fault(pc));
            if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
            else check("out_inst", out_inst, exp_q.pop_front());
            if (chk_gap && last_acc >= 0) check("gap", cycle - last_acc, 4);
            last_acc = cycle;
            pc = pc + 32'd4;
            set_pc();
        end
    endtask

    task automatic run_accepts(input int n, input int budget);
        int start;
        start = accepts;
        for (int i = 0; i < budget && (accepts - start) < n; i++) step();
        check("progress", accepts - start, n);
    endtask

    task automatic knobs(input int ar, input int dmin, input int dmax, input int rdy, input int fl);
        p_arready = ar; min_rdelay = dmin; max_rdelay = dmax; p_ready = rdy; p_flush = fl;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {arvalid, rready, out_valid, pc_adv, out_fault, araddr, out_inst, out_pc}, 0);
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] start_pc);
        @(negedge clk);
        rstn = 1'b0;
        flush = 0; arready = 0; rvalid = 0; out_ready = 0; rdata = '0; rresp = 2'b00;
        rd_q.delete();
        hold_ar = 0; hold_out = 0; last_acc = -1; flushed = 0; force_flush = 0;
        pc = start_pc;
        set_pc();
        pc_in = pc;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        flush = 0; arready = 0; rvalid = 0; out_ready = 0; rdata = '0; rresp = 2'b00;
        pc_in = '0;

        // Zero-wait memory, IDU always ready: one instruction every 4 cycles.
        knobs(100, 0, 0, 100, 0);
        do_reset(32'h8000_0000);
        chk_gap = 1;
        run_accepts(6, 60);
        chk_gap = 0;

        // Backpressure: buffer held, no new request, no pc_adv.
        knobs(100, 0, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = out_valid;
        end
        check("bp_reached_out", seen, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_arvalid", arvalid, 0);
        end
        knobs(100, 0, 0, 100, 0);
        run_accepts(2, 30);

        // Slow memory with stalled arready and delayed rvalid.
        knobs(30, 0, 4, 100, 0);
        run_accepts(10, 400);

        // Flush while the response is still outstanding.
        knobs(100, 2, 3, 100, 0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            seen = rready && !rvalid;
        end
        check("flush_wait_reached", seen, 1);
        force_flush = 1;
        force_pc = 32'h8000_1000;
        run_accepts(2, 60);

        // Flush together with out_ready while the buffer is full.
        knobs(100, 0, 1, 0, 0);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            seen = out_valid;
        end
        check("flush_out_reached", seen, 1);
        p_ready = 100;
        force_flush = 1;
        force_pc = 32'h8000_2000;
        step();
        @(posedge clk);
        #1 check("flush_out_drop", out_valid, 0);
        run_accepts(2, 40);

        // Mixed random traffic with redirects.
        knobs(60, 0, 3, 70, 8);
        for (int i = 0; i < 400; i++) step();

        // Address wrap-around and a faulting fetch at 0x0.
        knobs(100, 0, 0, 100, 0);
        do_reset(32'hFFFF_FFF8);
        run_accepts(4, 60);
        knobs(50, 0, 2, 50, 0);
        run_accepts(12, 400);

        // Asynchronous reset while a read is outstanding.
        knobs(100, 3, 3, 100, 0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = rready;
        end
        check("mid_wait_reached", seen, 1);
        rstn = 1'b0;
        #1 check_all_zero("async_reset");
        rd_q.delete();
        hold_ar = 0;
        hold_out = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
